// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: arbitrates ALU and load writebacks onto one register-file write port with a busy-bit scoreboard

// wb_fifo: small in-order queue of (address, data) writeback entries
module wb_fifo #(
   parameter int AW     = 5,
   parameter int BITS   = 64,
   parameter int QDEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic [AW-1:0]   push_addr,
   input  logic [BITS-1:0] push_data,
   input  logic            pop,
   output logic            full,
   output logic            empty,
   output logic [AW-1:0]   head_addr,
   output logic [BITS-1:0] head_data
);
   localparam int QW = $clog2(QDEPTH);
   logic [AW-1:0]   q_addr [QDEPTH];
   logic [BITS-1:0] q_data [QDEPTH];
   logic [QW-1:0]   wr_ptr, rd_ptr;
   logic [QW:0]     count;
   assign full      = count == (QW+1)'(QDEPTH);
   assign empty     = count == '0;
   assign head_addr = q_addr[rd_ptr];
   assign head_data = q_data[rd_ptr];
   // pointers wrap naturally because QDEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (QW+1)'(push) - (QW+1)'(pop);
      end
   end
   // entry storage needs no reset; count guards validity
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wr_ptr] <= push_addr;
         q_data[wr_ptr] <= push_data;
      end
   end
endmodule

module regfile_wb_scheduler #(
   parameter int DEPTH  = 32,
   parameter int BITS   = 64,
   parameter int QDEPTH = 2,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alu_valid,
   output logic             alu_ready,
   input  logic [AW-1:0]    alu_addr,
   input  logic [BITS-1:0]  alu_data,
   input  logic             mem_valid,
   output logic             mem_ready,
   input  logic [AW-1:0]    mem_addr,
   input  logic [BITS-1:0]  mem_data,
   input  logic             rsv_valid,
   output logic             rsv_ready,
   input  logic [AW-1:0]    rsv_addr,
   input  logic [AW-1:0]    query1_addr,
   input  logic [AW-1:0]    query2_addr,
   output logic             hazard1,
   output logic             hazard2,
   output logic [AW-1:0]    rf_addressw,
   output logic [BITS-1:0]  rf_writeData,
   output logic             rf_writeEn,
   output logic [DEPTH-1:0] busy
);
   logic            alu_full, alu_empty, mem_full, mem_empty;
   logic [AW-1:0]   alu_head_addr, mem_head_addr;
   logic [BITS-1:0] alu_head_data, mem_head_data;
   logic            alu_push, mem_push, grant_alu, grant_mem, fav_mem, rsv_fire;
   logic [DEPTH-1:0] busy_nx;
   assign alu_ready = rst_n && !alu_full;
   assign mem_ready = rst_n && !mem_full;
   assign alu_push  = alu_valid && alu_ready && alu_addr != '0;
   assign mem_push  = mem_valid && mem_ready && mem_addr != '0;
   assign grant_mem = !mem_empty && (alu_empty || fav_mem);
   assign grant_alu = !alu_empty && !grant_mem;
   assign rf_writeEn   = grant_alu || grant_mem;
   assign rf_addressw  = grant_mem ? mem_head_addr : grant_alu ? alu_head_addr : '0;
   assign rf_writeData = grant_mem ? mem_head_data : grant_alu ? alu_head_data : '0;
   assign rsv_ready = rsv_addr == '0 || !busy[rsv_addr] || (rf_writeEn && rf_addressw == rsv_addr);
   assign rsv_fire  = rsv_valid && rsv_ready && rsv_addr != '0;
   assign hazard1   = busy[query1_addr];
   assign hazard2   = busy[query2_addr];
   wb_fifo #(.AW(AW), .BITS(BITS), .QDEPTH(QDEPTH)) u_alu_q (
      .clk(clk), .rst_n(rst_n), .push(alu_push), .push_addr(alu_addr), .push_data(alu_data),
      .pop(grant_alu), .full(alu_full), .empty(alu_empty), .head_addr(alu_head_addr), .head_data(alu_head_data)
   );
   wb_fifo #(.AW(AW), .BITS(BITS), .QDEPTH(QDEPTH)) u_mem_q (
      .clk(clk), .rst_n(rst_n), .push(mem_push), .push_addr(mem_addr), .push_data(mem_data),
      .pop(grant_mem), .full(mem_full), .empty(mem_empty), .head_addr(mem_head_addr), .head_data(mem_head_data)
   );
   // round-robin pointer flips only when both heads competed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fav_mem <= 1'b1;
      else if (!alu_empty && !mem_empty) fav_mem <= !fav_mem;
   end
   // scoreboard update: issued write clears, accepted reservation sets and wins; x0 never busy
   always_comb begin
      busy_nx = '0;
      for (int i = 1; i < DEPTH; i++)
         busy_nx[i] = (busy[i] && !(rf_writeEn && rf_addressw == AW'(i))) || (rsv_fire && rsv_addr == AW'(i));
   end
   // scoreboard register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else busy <= busy_nx;
   end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed and random checks of the writeback scheduler
module tb_regfile_wb_scheduler;
   localparam int AW = 5;
   localparam int BITS = 64;
   logic clk, rst_n;
   logic alu_valid, alu_ready, mem_valid, mem_ready, rsv_valid, rsv_ready;
   logic [AW-1:0] alu_addr, mem_addr, rsv_addr, query1_addr, query2_addr, rf_addressw;
   logic [BITS-1:0] alu_data, mem_data, rf_writeData;
   logic hazard1, hazard2, rf_writeEn;
   logic [31:0] busy;
   int checks = 0;
   int errors = 0;

   regfile_wb_scheduler dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .rsv_valid(rsv_valid), .rsv_ready(rsv_ready), .rsv_addr(rsv_addr),
      .query1_addr(query1_addr), .query2_addr(query2_addr), .hazard1(hazard1), .hazard2(hazard2),
      .rf_addressw(rf_addressw), .rf_writeData(rf_writeData), .rf_writeEn(rf_writeEn), .busy(busy)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 0; alu_addr = 0; alu_data = 0;
      mem_valid = 0; mem_addr = 0; mem_data = 0;
      rsv_valid = 0; rsv_addr = 0; query1_addr = 0; query2_addr = 0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_n = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      #1;
      checks++; if (rf_writeEn !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", rf_writeEn); end
      checks++; if (rf_addressw !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", rf_addressw); end
      checks++; if (rf_writeData !== 64'd0) begin errors++; $display("FAIL reset_data got %0h exp 0", rf_writeData); end
      checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b%0b exp 00", alu_ready, mem_ready); end
      checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
      @(negedge clk);
      rst_n = 1;
      #1;
      checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0b%0b exp 11", alu_ready, mem_ready); end
   endtask

   task automatic test_single();
      apply_reset();
      alu_valid = 1; alu_addr = 5; alu_data = 64'hA;
      #1;
      checks++; if (rf_writeEn !== 1'b0) begin errors++; $display("FAIL single_pre_we got %0b exp 0", rf_writeEn); end
      tick();
      idle_inputs();
      #1;
      checks++; if (rf_writeEn !== 1'b1) begin errors++; $display("FAIL single_we got %0b exp 1", rf_writeEn); end
      checks++; if (rf_addressw !== 5'd5) begin errors++; $display("FAIL single_addr got %0d exp 5", rf_addressw); end
      checks++; if (rf_writeData !== 64'hA) begin errors++; $display("FAIL single_data got %0h exp a", rf_writeData); end
      tick();
      checks++; if (rf_writeEn !== 1'b0 || rf_addressw !== 5'd0 || rf_writeData !== 64'd0) begin errors++; $display("FAIL single_idle got %0b/%0d/%0h exp 0/0/0", rf_writeEn, rf_addressw, rf_writeData); end
   endtask

   task automatic test_alternate();
      int na, nm, ga, gm;
      logic acc_a, acc_m;
      apply_reset();
      na = 0; nm = 0; ga = 0; gm = 0;
      alu_valid = 1; alu_addr = 1; alu_data = 64'h100;
      mem_valid = 1; mem_addr = 2; mem_data = 64'h200;
      #1;
      for (int k = 1; k <= 9; k++) begin
         if (k >= 2) begin
            checks++; if (rf_writeEn !== 1'b1) begin errors++; $display("FAIL alt_we cycle %0d got %0b exp 1", k, rf_writeEn); end
            if (k % 2 == 0) begin
               checks++; if (rf_addressw !== 5'd2 || rf_writeData !== 64'(32'h200 + gm)) begin errors++; $display("FAIL alt_mem cycle %0d got %0d/%0h exp 2/%0h", k, rf_addressw, rf_writeData, 32'h200 + gm); end
               gm++;
            end else begin
               checks++; if (rf_addressw !== 5'd1 || rf_writeData !== 64'(32'h100 + ga)) begin errors++; $display("FAIL alt_alu cycle %0d got %0d/%0h exp 1/%0h", k, rf_addressw, rf_writeData, 32'h100 + ga); end
               ga++;
            end
         end
         if (k >= 3) begin
            checks++; if (alu_ready !== (k % 2 == 0) || mem_ready !== (k % 2 == 1)) begin errors++; $display("FAIL alt_ready cycle %0d got %0b%0b exp %0b%0b", k, alu_ready, mem_ready, k % 2 == 0, k % 2 == 1); end
         end
         acc_a = alu_ready; acc_m = mem_ready;
         tick();
         if (acc_a) begin na++; alu_data = 64'(32'h100 + na); end
         if (acc_m) begin nm++; mem_data = 64'(32'h200 + nm); end
      end
      idle_inputs();
      repeat (5) tick();
      checks++; if (rf_writeEn !== 1'b0) begin errors++; $display("FAIL alt_drain got %0b exp 0", rf_writeEn); end
   endtask

   task automatic test_scoreboard();
      apply_reset();
      rsv_valid = 1; rsv_addr = 7; query1_addr = 7; query2_addr = 7;
      #1;
      checks++; if (rsv_ready !== 1'b1 || hazard1 !== 1'b0) begin errors++; $display("FAIL sb_first got rdy %0b hz %0b exp 1 0", rsv_ready, hazard1); end
      tick();
      checks++; if (busy !== 32'h80 || hazard1 !== 1'b1 || hazard2 !== 1'b1) begin errors++; $display("FAIL sb_busy got %0h hz %0b%0b exp 80 11", busy, hazard1, hazard2); end
      checks++; if (rsv_ready !== 1'b0) begin errors++; $display("FAIL sb_refuse got %0b exp 0", rsv_ready); end
      tick();
      rsv_valid = 0; alu_valid = 1; alu_addr = 7; alu_data = 64'h77;
      tick();
      alu_valid = 0; rsv_valid = 1; rsv_addr = 7;
      #1;
      checks++; if (rf_writeEn !== 1'b1 || rf_addressw !== 5'd7 || rf_writeData !== 64'h77) begin errors++; $display("FAIL sb_issue got %0b/%0d/%0h exp 1/7/77", rf_writeEn, rf_addressw, rf_writeData); end
      checks++; if (hazard1 !== 1'b1 || rsv_ready !== 1'b1) begin errors++; $display("FAIL sb_clear_cycle got hz %0b rdy %0b exp 1 1", hazard1, rsv_ready); end
      tick();
      rsv_valid = 0;
      #1;
      checks++; if (busy !== 32'h80 || rf_writeEn !== 1'b0) begin errors++; $display("FAIL sb_set_wins got %0h we %0b exp 80 0", busy, rf_writeEn); end
      alu_valid = 1;
      tick();
      alu_valid = 0;
      #1;
      checks++; if (hazard1 !== 1'b1) begin errors++; $display("FAIL sb_hz_issue got %0b exp 1", hazard1); end
      tick();
      checks++; if (hazard1 !== 1'b0 || busy !== 32'd0) begin errors++; $display("FAIL sb_released got hz %0b busy %0h exp 0 0", hazard1, busy); end
      rsv_valid = 1; rsv_addr = 0;
      #1;
      checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL sb_rsv0_ready got %0b exp 1", rsv_ready); end
      tick();
      rsv_valid = 0;
      checks++; if (busy !== 32'd0) begin errors++; $display("FAIL sb_rsv0_busy got %0h exp 0", busy); end
   endtask

   task automatic test_x0();
      apply_reset();
      alu_valid = 1; alu_addr = 0; alu_data = 64'h11;
      mem_valid = 1; mem_addr = 0; mem_data = 64'h22;
      #1;
      checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %0b%0b exp 11", alu_ready, mem_ready); end
      tick();
      idle_inputs();
      #1;
      checks++; if (rf_writeEn !== 1'b0) begin errors++; $display("FAIL x0_we got %0b exp 0", rf_writeEn); end
      tick();
      checks++; if (rf_writeEn !== 1'b0 || busy !== 32'd0) begin errors++; $display("FAIL x0_after got %0b busy %0h exp 0 0", rf_writeEn, busy); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      alu_valid = 1; alu_addr = 3; alu_data = 64'h33;
      mem_valid = 1; mem_addr = 4; mem_data = 64'h44;
      rsv_valid = 1; rsv_addr = 9;
      tick();
      rsv_valid = 0;
      repeat (2) tick();
      checks++; if (rf_writeEn !== 1'b1 || busy !== 32'h200) begin errors++; $display("FAIL mid_pre got %0b busy %0h exp 1 200", rf_writeEn, busy); end
      #2;
      rst_n = 0;
      #1;
      checks++; if (rf_writeEn !== 1'b0 || busy !== 32'd0 || alu_ready !== 1'b0) begin errors++; $display("FAIL mid_in_reset got %0b busy %0h rdy %0b exp 0 0 0", rf_writeEn, busy, alu_ready); end
      idle_inputs();
      @(negedge clk);
      rst_n = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (rf_writeEn !== 1'b0 || busy !== 32'd0) begin errors++; $display("FAIL mid_stale cycle %0d got %0b busy %0h exp 0 0", k, rf_writeEn, busy); end
      end
   endtask

   task automatic test_random();
      logic [AW+BITS-1:0] exp_a[$];
      logic [AW+BITS-1:0] exp_m[$];
      logic [AW+BITS-1:0] got, want;
      apply_reset();
      for (int c = 0; c < 206; c++) begin
         alu_valid = c < 200 && $urandom_range(0, 1) == 1;
         mem_valid = c < 200 && $urandom_range(0, 1) == 1;
         alu_addr = AW'($urandom_range(0, 31));
         mem_addr = AW'($urandom_range(0, 31));
         alu_data = {1'b0, 31'd0, 32'($urandom)};
         mem_data = {1'b1, 31'd0, 32'($urandom)};
         #1;
         if (rf_writeEn === 1'b1) begin
            got = {rf_addressw, rf_writeData};
            checks++;
            if (rf_writeData[BITS-1] ? exp_m.size() == 0 : exp_a.size() == 0) begin
               errors++; $display("FAIL rand_unexpected cycle %0d got %0d/%0h exp no write", c, rf_addressw, rf_writeData);
            end else begin
               want = rf_writeData[BITS-1] ? exp_m.pop_front() : exp_a.pop_front();
               if (got !== want) begin errors++; $display("FAIL rand_order cycle %0d got %0h exp %0h", c, got, want); end
            end
         end
         if (alu_valid && alu_ready && alu_addr != 0) exp_a.push_back({alu_addr, alu_data});
         if (mem_valid && mem_ready && mem_addr != 0) exp_m.push_back({mem_addr, mem_data});
         tick();
      end
      checks++; if (exp_a.size() != 0 || exp_m.size() != 0) begin errors++; $display("FAIL rand_lost got %0d/%0d pending exp 0/0", exp_a.size(), exp_m.size()); end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_scoreboard();
      test_x0();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
